// File: rtl/fpu_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_conv_arbiter
// Purpose  : Shares one fixed-latency ftoi conversion unit between two
//            valid/ready requesters. A round-robin grant picks at most one
//            operand per cycle. A tag pipeline routes each result to the
//            response FIFO of the requester that issued it. Per-requester
//            credit counters reserve FIFO space at issue time, so the unit
//            never needs backpressure.
// Ports    : clk, rstn                    - clock, async active-low reset
//            reqN_valid/ready/x (N=0,1)   - operand request handshake
//            respN_valid/ready/y (N=0,1)  - result response FIFO head
//            unit_x / unit_y              - operand to / result from ftoi
// Revision : 1.0 - initial release
// ============================================================================
module fpu_conv_arbiter #(
  parameter int LAT   = 1,  // ftoi latency in clock edges, 1..8
  parameter int DEPTH = 4   // per-requester FIFO depth / credit limit
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_y,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_y,
  output logic [31:0] unit_x,
  input  logic [31:0] unit_y
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]     req_valid;
  logic [1:0]     elig;
  logic [1:0]     grant;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [31:0]    req_x  [2];
  logic [31:0]    resp_y [2];
  logic           prio_q;
  logic [LAT-1:0] tag_vld_q;
  logic [LAT-1:0] tag_id_q;
  logic [LAT:0]   tag_vld_d;
  logic [LAT:0]   tag_id_d;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_x[0]   = req0_x;
  assign req_x[1]   = req1_x;

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_y     = resp_y[0];
  assign resp1_y     = resp_y[1];

  // Round-robin pick. Eligibility is computed from registered credits only,
  // so no combinational path exists from resp*_ready to req*_ready.
  always_comb begin
    grant = 2'b00;
    if (elig[0] && (!elig[1] || !prio_q)) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    unit_x = 32'h0;
    if (grant[0]) begin
      unit_x = req_x[0];
    end else if (grant[1]) begin
      unit_x = req_x[1];
    end
  end

  // Tag pipeline mirrors the unit latency: stage 0 is loaded on the issue
  // edge, so the last stage is valid exactly on the edge that unit_y holds
  // the matching result.
  assign tag_vld_d = {tag_vld_q, |grant};
  assign tag_id_d  = {tag_id_q, grant[1]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      prio_q    <= 1'b0;
    end else begin
      tag_vld_q <= tag_vld_d[LAT-1:0];
      tag_id_q  <= tag_id_d[LAT-1:0];
      if (grant[0]) begin
        prio_q <= 1'b1;
      end else if (grant[1]) begin
        prio_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_req
    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] wr_q;
    logic [CW-1:0] rd_q;
    logic [CW-1:0] credit_q;
    logic          empty;
    logic          pop;
    logic          capture;

    // Pointer MSB distinguishes full from empty; only equality is needed
    // here since credit already rules out overflow.
    assign empty         = (wr_q == rd_q);
    assign resp_valid[i] = !empty;
    assign resp_y[i]     = empty ? 32'h0 : mem_q[rd_q[AW-1:0]];
    assign pop           = resp_valid[i] && resp_ready[i];
    assign capture       = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == 1'(i));
    assign elig[i]       = rstn && req_valid[i] && (credit_q < DEPTH_C);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_q     <= '0;
        rd_q     <= '0;
        credit_q <= '0;
      end else begin
        if (capture) begin
          wr_q <= wr_q + 1'b1;
        end
        if (pop) begin
          rd_q <= rd_q + 1'b1;
        end
        if (grant[i] && !pop) begin
          credit_q <= credit_q + 1'b1;
        end else if (!grant[i] && pop) begin
          credit_q <= credit_q - 1'b1;
        end
      end
    end

    // Storage needs no reset: the output mux hides it while empty.
    always_ff @(posedge clk) begin
      if (capture) begin
        mem_q[wr_q[AW-1:0]] <= unit_y;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_conv_arbiter
// Purpose  : Self-checking bench for fpu_conv_arbiter. Two instances: LAT=1
//            (dut) and LAT=3 (dut3), each wired to a behavioural ftoi model.
//            Expected results are queued when a handshake is seen and
//            compared when the matching response is popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_conv_arbiter;

  localparam logic [31:0] F_3P0  = 32'h40400000;
  localparam logic [31:0] F_M3P0 = 32'hC0400000;
  localparam logic [31:0] F_1000 = 32'h447A0000;
  localparam logic [31:0] F_ZERO = 32'h00000000;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  // LAT=1 instance signals
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] req0_x = 32'h0, req1_x = 32'h0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_y, resp1_y, unit_x, unit_y;

  // LAT=3 instance signals
  logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic        b_resp0_ready = 1'b0, b_resp1_ready = 1'b0;
  logic [31:0] b_req0_x = 32'h0, b_req1_x = 32'h0;
  logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid;
  logic [31:0] b_resp0_y, b_resp1_y, b_unit_x, b_unit_y;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q0[$], q1[$], bq0[$], bq1[$];
  logic        mprio;
  logic [31:0] mon_e;

  fpu_conv_arbiter #(.LAT(1), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y),
    .unit_x(unit_x), .unit_y(unit_y)
  );

  fpu_conv_arbiter #(.LAT(3), .DEPTH(4)) dut3 (
    .clk(clk), .rstn(rstn),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_x(b_req0_x),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_x(b_req1_x),
    .resp0_valid(b_resp0_valid), .resp0_ready(b_resp0_ready), .resp0_y(b_resp0_y),
    .resp1_valid(b_resp1_valid), .resp1_ready(b_resp1_ready), .resp1_y(b_resp1_y),
    .unit_x(b_unit_x), .unit_y(b_unit_y)
  );

  // Behavioural float->int conversion (truncate toward zero).
  function automatic logic [31:0] ftoi(input logic [31:0] x);
    int          e;
    logic [31:0] m;
    logic [31:0] r;
    e = int'(x[30:23]) - 127;
    m = {8'h0, 1'b1, x[22:0]};
    if (e < 0)        r = 32'h0;
    else if (e >= 23) r = m << (e - 23);
    else              r = m >> (23 - e);
    if (x[31]) r = -r;
    return r;
  endfunction

  // Expected integer for each stimulus operand used by the bench.
  function automatic logic [31:0] exp_of(input logic [31:0] x);
    case (x)
      F_3P0:   return 32'h00000003;
      F_M3P0:  return 32'hFFFFFFFD;
      F_1000:  return 32'h000003E8;
      F_ZERO:  return 32'h00000000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // ftoi models: LAT registers, not reset (stale results must be ignored).
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= ftoi(unit_x);
    pipe3[0] <= ftoi(b_unit_x);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign unit_y   = pipe1;
  assign b_unit_y = pipe3[2];

  // Scoreboard: pops happen on the next rising edge when valid && ready.
  always @(negedge clk) begin
    #1;
    if (resp0_valid && resp0_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL sb_resp0 unexpected result got %h want none", resp0_y);
      end else begin
        mon_e = q0.pop_front();
        if (resp0_y !== mon_e) begin
          errors++; $display("FAIL sb_resp0 got %h want %h", resp0_y, mon_e);
        end
      end
    end
    if (resp1_valid && resp1_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL sb_resp1 unexpected result got %h want none", resp1_y);
      end else begin
        mon_e = q1.pop_front();
        if (resp1_y !== mon_e) begin
          errors++; $display("FAIL sb_resp1 got %h want %h", resp1_y, mon_e);
        end
      end
    end
    if (b_resp0_valid && b_resp0_ready) begin
      checks++;
      if (bq0.size() == 0) begin
        errors++; $display("FAIL sb_lat3_resp0 unexpected result got %h want none", b_resp0_y);
      end else begin
        mon_e = bq0.pop_front();
        if (b_resp0_y !== mon_e) begin
          errors++; $display("FAIL sb_lat3_resp0 got %h want %h", b_resp0_y, mon_e);
        end
      end
    end
    if (b_resp1_valid && b_resp1_ready) begin
      checks++;
      if (bq1.size() == 0) begin
        errors++; $display("FAIL sb_lat3_resp1 unexpected result got %h want none", b_resp1_y);
      end else begin
        mon_e = bq1.pop_front();
        if (b_resp1_y !== mon_e) begin
          errors++; $display("FAIL sb_lat3_resp1 got %h want %h", b_resp1_y, mon_e);
        end
      end
    end
  end

  task automatic test_reset;
    #1 rstn = 1'b0;
    req0_valid = 1'b1; req0_x = F_3P0;
    req1_valid = 1'b1; req1_x = F_1000;
    #2;
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
    checks++; if ({resp1_valid, resp0_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_resp_valid got %b want 00", {resp1_valid, resp0_valid}); end
    checks++; if (unit_x !== 32'h0) begin
      errors++; $display("FAIL reset_unit_x got %h want 00000000", unit_x); end
    checks++; if (resp0_y !== 32'h0 || resp1_y !== 32'h0) begin
      errors++; $display("FAIL reset_resp_y got %h/%h want 0/0", resp0_y, resp1_y); end
    repeat (2) @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rstn = 1'b1;
    mprio = 1'b0;
  endtask

  task automatic test_single;
    resp0_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_x = F_3P0;
    #1;
    checks++; if (req0_ready !== 1'b1 || unit_x !== F_3P0) begin
      errors++; $display("FAIL single_issue ready %b unit_x %h want 1 %h", req0_ready, unit_x, F_3P0); end
    if (req0_ready) q0.push_back(exp_of(F_3P0));
    mprio = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_early_valid got %b want 0", resp0_valid); end
    @(negedge clk); #1;
    checks++; if (resp0_valid !== 1'b1 || resp0_y !== 32'h00000003) begin
      errors++; $display("FAIL single_result valid %b y %h want 1 00000003", resp0_valid, resp0_y); end
    @(negedge clk); #1;
    checks++; if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_drained got %b want 0", resp0_valid); end
  endtask

  task automatic test_simultaneous;
    logic [1:0] want;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_x = F_M3P0;
      req1_valid = 1'b1; req1_x = F_1000;
      #1;
      want = mprio ? 2'b10 : 2'b01;
      checks++; if ({req1_ready, req0_ready} !== want) begin
        errors++; $display("FAIL simul_grant cycle %0d got %b want %b", n, {req1_ready, req0_ready}, want); end
      if (req0_ready) q0.push_back(exp_of(F_M3P0));
      if (req1_ready) q1.push_back(exp_of(F_1000));
      mprio = ~mprio;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_credit_stall;
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_x = F_ZERO;
      #1;
      checks++; if (req1_ready !== (n < 4)) begin
        errors++; $display("FAIL stall_accept cycle %0d got %b want %b", n, req1_ready, (n < 4)); end
      if (req1_ready) q1.push_back(exp_of(F_ZERO));
    end
    mprio = 1'b0;
    @(negedge clk);
    resp1_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0 || resp1_valid !== 1'b1) begin
      errors++; $display("FAIL stall_pop_cycle ready %b resp_valid %b want 0 1", req1_ready, resp1_valid); end
    @(negedge clk); #1;
    checks++; if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL stall_reenable got %b want 1", req1_ready); end
    if (req1_ready) q1.push_back(exp_of(F_ZERO));
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_fairness;
    int         c1;
    logic [1:0] want;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    c1 = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_x = F_3P0;
      req1_valid = 1'b1; req1_x = F_1000;
      #1;
      want = ((c1 < 4) && mprio) ? 2'b10 : 2'b01;
      checks++; if ({req1_ready, req0_ready} !== want) begin
        errors++; $display("FAIL fair_stalled cycle %0d got %b want %b", n, {req1_ready, req0_ready}, want); end
      if (req0_ready) q0.push_back(exp_of(F_3P0));
      if (req1_ready) q1.push_back(exp_of(F_1000));
      if (want == 2'b10) begin c1++; mprio = 1'b0; end
      else mprio = 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      resp1_ready = 1'b1;
      #1;
      checks++; if ({req1_ready, req0_ready} !== seq[n]) begin
        errors++; $display("FAIL fair_resume cycle %0d got %b want %b", n, {req1_ready, req0_ready}, seq[n]); end
      if (req0_ready) q0.push_back(exp_of(F_3P0));
      if (req1_ready) q1.push_back(exp_of(F_1000));
    end
    mprio = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    resp0_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_x = F_3P0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_issue got %b want 1", req0_ready); end
    @(posedge clk);
    #1 rstn = 1'b0;
    req0_valid = 1'b0;
    q0.delete();
    #5 rstn = 1'b1;
    mprio = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      checks++; if (resp0_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_discard cycle %0d got %b want 0", n, resp0_valid); end
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_x = F_3P0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_reissue got %b want 1", req0_ready); end
    if (req0_ready) q0.push_back(exp_of(F_3P0));
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (resp0_valid !== 1'b1 || resp0_y !== 32'h00000003) begin
      errors++; $display("FAIL midrst_result valid %b y %h want 1 00000003", resp0_valid, resp0_y); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lat3;
    logic [31:0] tab0 [4];
    logic [31:0] tab1 [4];
    int          i0, i1;
    tab0 = '{F_3P0, F_1000, F_3P0, F_M3P0};
    tab1 = '{F_1000, F_3P0, F_M3P0, F_1000};
    b_resp0_ready = 1'b1; b_resp1_ready = 1'b1;
    @(negedge clk);
    b_req0_valid = 1'b1; b_req0_x = F_3P0;
    #1;
    checks++; if (b_req0_ready !== 1'b1) begin
      errors++; $display("FAIL lat3_issue got %b want 1", b_req0_ready); end
    if (b_req0_ready) bq0.push_back(exp_of(F_3P0));
    @(negedge clk);
    b_req0_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      checks++; if (b_resp0_valid !== 1'b0) begin
        errors++; $display("FAIL lat3_early cycle %0d got %b want 0", n + 1, b_resp0_valid); end
    end
    @(negedge clk); #1;
    checks++; if (b_resp0_valid !== 1'b1 || b_resp0_y !== 32'h00000003) begin
      errors++; $display("FAIL lat3_result valid %b y %h want 1 00000003", b_resp0_valid, b_resp0_y); end
    i0 = 0; i1 = 0;
    for (int n = 0; n < 20 && (i0 < 4 || i1 < 4); n++) begin
      @(negedge clk);
      b_req0_valid = (i0 < 4); b_req0_x = (i0 < 4) ? tab0[i0] : 32'h0;
      b_req1_valid = (i1 < 4); b_req1_x = (i1 < 4) ? tab1[i1] : 32'h0;
      #1;
      if (b_req0_ready) begin bq0.push_back(exp_of(b_req0_x)); i0++; end
      if (b_req1_ready) begin bq1.push_back(exp_of(b_req1_x)); i1++; end
    end
    @(negedge clk);
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (i0 != 4 || i1 != 4) begin
      errors++; $display("FAIL lat3_accepts got %0d/%0d want 4/4", i0, i1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_credit_stall();
    test_fairness();
    test_reset_midflight();
    test_lat3();
    checks++;
    if (q0.size() + q1.size() + bq0.size() + bq1.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d %0d %0d %0d want 0 0 0 0",
               q0.size(), q1.size(), bq0.size(), bq1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
